writeback_buffer: RTL

- Sits directly downstream of the cache controller's eviction path, between the data cache and data memory.
- On a dirty miss, the controller pushes the victim block (address and full line) into this block.
- The buffer stores up to DEPTH victim blocks and drains them to data memory one word at a time over a ready/ack interface.
- While a block is still held here, it answers refill lookups, so a miss to a just-evicted line never reads stale memory.

---
 rtl/writeback_buffer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/writeback_buffer.sv
// writeback_buffer
// ----------------
// Victim (write-back) buffer between the data cache eviction path and data
// memory. Dirty victim blocks are pushed in whole, held in a small circular
// queue, and drained to memory one word at a time over a we/ack handshake.
// While a block is held, refill lookups that hit it are served from here so
// a miss to a just-evicted line never sees stale memory contents.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   wb_valid/ready victim push handshake (ready = not full)
//   wb_addr        victim block byte address (block offset ignored)
//   wb_data        victim line, word i at [i*WORD_W +: WORD_W]
//   lk_valid/addr  combinational refill lookup (block offset ignored)
//   lk_hit/data    lookup result; youngest matching entry, 0 on miss
//   mem_we/addr/wdata  word write to memory, held stable until mem_ack
//   mem_ack        memory accepted the current word (ignored while mem_we=0)
//   empty, full    occupancy status
module writeback_buffer #(
    parameter int WORD_W = 32,
    parameter int WORDS  = 4,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [WORD_W*WORDS-1:0]  wb_data,
    input  logic                     lk_valid,
    input  logic [ADDR_W-1:0]        lk_addr,
    output logic                     lk_hit,
    output logic [WORD_W*WORDS-1:0]  lk_data,
    output logic                     mem_we,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic [WORD_W-1:0]        mem_wdata,
    input  logic                     mem_ack,
    output logic                     empty,
    output logic                     full
);

    localparam int LINE_W  = WORD_W * WORDS;
    localparam int OFF_W   = $clog2(LINE_W / 8);   // block offset bits
    localparam int BYTE_SH = $clog2(WORD_W / 8);   // word index -> byte offset
    localparam int IDX_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Force the block offset to zero so stored and compared addresses agree.
    function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

    logic [ADDR_W-1:0] entry_addr_q [DEPTH];
    logic [LINE_W-1:0] entry_line_q [DEPTH];

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [PTR_W-1:0]  head_q,  head_d;
    logic [PTR_W-1:0]  tail_q,  tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic push;
    logic pop;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: the entry storage has no reset; an entry is only ever read when
    // count_q marks it valid, so stale contents after reset are invisible.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            entry_addr_q[tail_q] <= blk_align(wb_addr);
            entry_line_q[tail_q] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Drain FSM: next state
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                // Starting from the registered count costs one bubble cycle
                // between blocks but keeps the ack path out of the decision.
                if (count_q != '0) begin
                    state_d = WRITE;
                    idx_d   = '0;
                end
            end
            WRITE: begin
                if (mem_ack) begin
                    if (idx_q == LAST_IDX) begin
                        pop     = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Queue pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        // Acceptance uses the registered full flag: a pop on the same edge
        // does not free a slot until the following cycle.
        push    = wb_valid && !full;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap.
        head_d  = pop  ? head_q + 1'b1 : head_q;
        tail_d  = push ? tail_q + 1'b1 : tail_q;
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // ------------------------------------------------------------------
    // Drain FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = (state_q == WRITE);
        mem_addr  = '0;
        mem_wdata = '0;
        if (state_q == WRITE) begin
            mem_addr = entry_addr_q[head_q] + (ADDR_W'(idx_q) << BYTE_SH);
            for (int w = 0; w < WORDS; w++) begin
                if (idx_q == IDX_W'(w)) begin
                    mem_wdata = entry_line_q[head_q][w*WORD_W +: WORD_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Refill lookup
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] lk_blk;
    logic [PTR_W-1:0]  slot;

    always_comb begin
        lk_hit  = 1'b0;
        lk_data = '0;
        lk_blk  = blk_align(lk_addr);
        slot    = head_q;
        if (lk_valid) begin
            // Scan oldest to youngest; a later match overrides an earlier
            // one, so the youngest copy of a twice-evicted block wins. The
            // head stays searchable until its final word is acknowledged.
            for (int i = 0; i < DEPTH; i++) begin
                slot = head_q + PTR_W'(i);
                if ((CNT_W'(i) < count_q) && (entry_addr_q[slot] == lk_blk)) begin
                    lk_hit  = 1'b1;
                    lk_data = entry_line_q[slot];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Status
    // ------------------------------------------------------------------
    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign wb_ready = !full;

endmodule
